// File: rtl/scr1_pipe_div.sv
// scr1_pipe_div: 32-bit radix-2 restoring divider for DIV/DIVU/REM/REMU.
// It takes 32 iteration cycles, or a single cycle for a zero divisor when FAST_ZERO is set.
module scr1_pipe_div #(
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exu2div_cmd_vd_i,
    input  logic [1:0]  exu2div_cmd_i,
    input  logic [31:0] exu2div_op1_i,
    input  logic [31:0] exu2div_op2_i,
    output logic        div2exu_res_rdy_o,
    output logic [31:0] div2exu_res_o
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [31:0] rem_q, rem_d, quot_q, quot_d, div_q, div_d;
    logic        s1_q, s1_d, s2_q, s2_d;
    logic        sgn_op, fast_zero;
    logic [31:0] abs1, abs2, quot_res, rem_res;
    logic [32:0] shifted;
    logic        ge;
    assign sgn_op    = ~exu2div_cmd_i[0];
    assign abs1      = (sgn_op & exu2div_op1_i[31]) ? -exu2div_op1_i : exu2div_op1_i;
    assign abs2      = (sgn_op & exu2div_op2_i[31]) ? -exu2div_op2_i : exu2div_op2_i;
    assign fast_zero = FAST_ZERO && (exu2div_op2_i == '0);
    // The remainder stays below the divisor, so one extra bit makes the compare exact
    assign shifted   = {rem_q, quot_q[31]};
    assign ge        = shifted >= {1'b0, div_q};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = exu2div_cmd_vd_i ? (fast_zero ? DONE : ITER) : IDLE;
            ITER:    state_d = !exu2div_cmd_vd_i ? IDLE : (cnt_q == '0 ? DONE : ITER);
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        cnt_d  = cnt_q;
        cmd_d  = cmd_q;
        rem_d  = rem_q;
        quot_d = quot_q;
        div_d  = div_q;
        s1_d   = s1_q;
        s2_d   = s2_q;
        if (state_q == IDLE && exu2div_cmd_vd_i) begin
            cmd_d  = exu2div_cmd_i;
            s1_d   = sgn_op & exu2div_op1_i[31];
            s2_d   = sgn_op & exu2div_op2_i[31];
            div_d  = abs2;
            cnt_d  = 5'd31;
            rem_d  = fast_zero ? abs1 : '0;
            quot_d = fast_zero ? '1 : abs1;
        end else if (state_q == ITER && exu2div_cmd_vd_i) begin
            cnt_d  = (cnt_q == '0) ? '0 : cnt_q - 5'd1;
            rem_d  = ge ? 32'(shifted - {1'b0, div_q}) : shifted[31:0];
            quot_d = {quot_q[30:0], ge};
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            cmd_q  <= '0;
            rem_q  <= '0;
            quot_q <= '0;
            div_q  <= '0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            cmd_q  <= cmd_d;
            rem_q  <= rem_d;
            quot_q <= quot_d;
            div_q  <= div_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
        end
    end
    // A zero divisor keeps the all-ones quotient; the remainder follows the dividend sign
    assign quot_res = ((s1_q ^ s2_q) && div_q != '0) ? -quot_q : quot_q;
    assign rem_res  = s1_q ? -rem_q : rem_q;
    always_comb begin
        div2exu_res_rdy_o = (state_q == DONE);
        div2exu_res_o     = !div2exu_res_rdy_o ? '0 : (cmd_q[1] ? rem_res : quot_res);
    end
endmodule

// File: tb/tb_scr1_pipe_div.sv
// tb_scr1_pipe_div: vector table, corner sequences and random ops against an arithmetic model.
// Two instances share the inputs: u_fz (FAST_ZERO=1) and u_sl (FAST_ZERO=0).
module tb_scr1_pipe_div;
    logic        clk = 1'b0, rst_n = 1'b0, vd = 1'b0;
    logic [1:0]  cmd = '0;
    logic [31:0] op1 = '0, op2 = '0;
    logic        rdy_f, rdy_s;
    logic [31:0] res_f, res_s;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    scr1_pipe_div #(.FAST_ZERO(1'b1)) u_fz (
        .clk(clk), .rst_n(rst_n), .exu2div_cmd_vd_i(vd), .exu2div_cmd_i(cmd),
        .exu2div_op1_i(op1), .exu2div_op2_i(op2),
        .div2exu_res_rdy_o(rdy_f), .div2exu_res_o(res_f));
    scr1_pipe_div #(.FAST_ZERO(1'b0)) u_sl (
        .clk(clk), .rst_n(rst_n), .exu2div_cmd_vd_i(vd), .exu2div_cmd_i(cmd),
        .exu2div_op1_i(op1), .exu2div_op2_i(op2),
        .div2exu_res_rdy_o(rdy_s), .div2exu_res_o(res_s));

    typedef struct {
        bit          sel;
        logic [1:0]  c;
        logic [31:0] a, b, exp;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!c[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return c[1] ? r : q;
    endfunction

    // Cycle n is the n-th clock period after the edge that samples the command.
    task automatic run_op(input bit sel, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                          input bit scramble, output logic [31:0] r, output int lat);
        @(negedge clk);
        vd = 1'b1; cmd = c; op1 = a; op2 = b;
        @(posedge clk);
        lat = 0;
        r = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (scramble) begin
                op1 = $urandom;
                op2 = $urandom;
            end
            if (sel ? rdy_s : rdy_f) begin
                lat = n;
                r = sel ? res_s : res_f;
                break;
            end
        end
        vd = 1'b0;
        @(negedge clk);
        chk("pulse_end", {31'd0, sel ? rdy_s : rdy_f}, 32'd0);
        chk("res_zero_idle", sel ? res_s : res_f, 32'd0);
    endtask

    vec_t        vt[12];
    logic [31:0] r, r2, a, b;
    logic [1:0]  c;
    int          lat, n1, n2;
    bit          seen, sel;

    initial begin
        vt[0]  = '{0, 2'b01, 32'd100,       32'd7,         32'd14,        33};
        vt[1]  = '{0, 2'b11, 32'd100,       32'd7,         32'd2,         33};
        vt[2]  = '{0, 2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vt[3]  = '{0, 2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vt[4]  = '{0, 2'b00, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1};
        vt[5]  = '{0, 2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1};
        vt[6]  = '{1, 2'b00, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 33};
        vt[7]  = '{1, 2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 33};
        vt[8]  = '{0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
        vt[9]  = '{0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
        vt[10] = '{0, 2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vt[11] = '{1, 2'b11, 32'd5,         32'd0,         32'd5,         33};

        #12;
        chk("reset_rdy", {31'd0, rdy_f | rdy_s}, 32'd0);
        chk("reset_res", res_f | res_s, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            run_op(vt[i].sel, vt[i].c, vt[i].a, vt[i].b, 1'b0, r, lat);
            chk($sformatf("vec%0d_res", i), r, vt[i].exp);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
        end

        // Abort: cmd_vd low from cycle 10, no result may appear
        @(negedge clk);
        vd = 1'b1; cmd = 2'b01; op1 = 32'd1000; op2 = 32'd3;
        @(posedge clk);
        seen = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 10) vd = 1'b0;
            seen |= rdy_f | rdy_s;
        end
        chk("abort_no_rdy", {31'd0, seen}, 32'd0);
        run_op(0, 2'b01, 32'd9, 32'd3, 1'b0, r, lat);
        chk("after_abort_res", r, 32'd3);
        chk("after_abort_lat", lat, 33);

        // Back-to-back: cmd_vd held through DONE restarts after one idle cycle
        @(negedge clk);
        vd = 1'b1; cmd = 2'b01; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk);
        n1 = 0; n2 = 0; r = 'x; r2 = 'x;
        for (int n = 1; n <= 80 && n2 == 0; n++) begin
            @(negedge clk);
            if (rdy_f) begin
                if (n1 == 0) begin n1 = n; r = res_f; end
                else begin n2 = n; r2 = res_f; end
            end
        end
        vd = 1'b0;
        chk("b2b_first_lat", n1, 33);
        chk("b2b_second_lat", n2, 67);
        chk("b2b_first_res", r, 32'd14);
        chk("b2b_second_res", r2, 32'd14);
        repeat (2) @(negedge clk);

        // Reset at cycle 20 of a DIV
        @(negedge clk);
        vd = 1'b1; cmd = 2'b00; op1 = -32'sd100; op2 = 32'd7;
        @(posedge clk);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        vd = 1'b0;
        #1;
        chk("rst_mid_rdy", {31'd0, rdy_f | rdy_s}, 32'd0);
        chk("rst_mid_res", res_f | res_s, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 2'b00, -32'sd100, 32'd7, 1'b0, r, lat);
        chk("after_rst_res", r, 32'hFFFF_FFF2);
        chk("after_rst_lat", lat, 33);

        // Asynchronous reset while the result is being presented
        @(negedge clk);
        vd = 1'b1; cmd = 2'b10; op1 = 32'd77; op2 = 32'd0;
        @(posedge clk);
        @(negedge clk);
        chk("done_rdy_before_rst", {31'd0, rdy_f}, 32'd1);
        chk("done_res_before_rst", res_f, 32'd77);
        rst_n = 1'b0;
        vd = 1'b0;
        #1;
        chk("rst_done_rdy", {31'd0, rdy_f}, 32'd0);
        chk("rst_done_res", res_f, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random ops, operands scrambled while iterating
        for (int k = 0; k < 30; k++) begin
            sel = 1'($urandom);
            c = 2'($urandom);
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = $urandom_range(1, 300);
                default: b = $urandom;
            endcase
            if (k == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; c = 2'b00; end
            run_op(sel, c, a, b, 1'b1, r, lat);
            chk($sformatf("rnd%0d_res c=%0d a=%h b=%h", k, c, a, b), r, ref_res(c, a, b));
            chk($sformatf("rnd%0d_lat", k), lat, (b == 0 && !sel) ? 1 : 33);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
